// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared types and constants for the convolution-engine feeder.
//            Feeder FSM state encoding, beat/result widths and the engine
//            state codes the optional checker compares against.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ARM    = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int BEAT_W = 64;
  localparam int RES_W  = 25;

  localparam logic [7:0] ST_IDLE = 8'h00;
  localparam logic [7:0] ST_KERN = 8'h01;

endpackage
`default_nettype wire

// File: rtl/conv_res_fifo.sv
`default_nettype none
// ============================================================================
// Module   : conv_res_fifo
// Purpose  : Synchronous FIFO for engine result pairs. A push while full is
//            accepted only if a pop happens in the same cycle; otherwise the
//            push is ignored (the caller flags the loss). dout reads 0 when
//            the FIFO is empty.
// Ports    : clk, rst_n      - clock, async active-low reset
//            push, din       - write request and data
//            pop             - read request (ignored when empty)
//            dout            - head entry
//            full, empty     - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module conv_res_fifo
  import conv_pkg::*;
#(
  parameter int WIDTH = 50,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_pop;
  logic             do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/conv_feeder.sv
`default_nettype none
// ============================================================================
// Module   : conv_feeder
// Purpose  : Buffers one kernel+image job from a valid/ready stream, then
//            replays it to the 4x4 convolution engine one 8-byte beat per
//            cycle while holding start_conv, and captures result pairs on
//            rising edges of the engine's write_o into a result FIFO.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            go / busy / done           - job control and status
//            src_valid/ready/data       - incoming job beats
//            start_conv, Idata0..7      - engine drive (registered)
//            write_o, ostate, Odata0/1  - engine results and state
//            res_valid/ready/data       - result stream {Odata1, Odata0}
//            ovf                        - sticky result-loss flag
//            chk_err                    - sticky engine-state error
//                                         (only with CONV_FEEDER_CHECK_EN)
// Config   : CONV_FEEDER_CHECK_EN enables the engine-state checker.
// Revision : 1.0 - initial release
// ============================================================================
module conv_feeder
  import conv_pkg::*;
#(
  parameter int KBEATS    = 2,
  parameter int IBEATS    = 16,
  parameter int DRAIN_CYC = 8,
  parameter int RDEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  output logic                 busy,
  output logic                 done,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [BEAT_W-1:0]    src_data,
  output logic                 start_conv,
  output logic [7:0]           Idata0,
  output logic [7:0]           Idata1,
  output logic [7:0]           Idata2,
  output logic [7:0]           Idata3,
  output logic [7:0]           Idata4,
  output logic [7:0]           Idata5,
  output logic [7:0]           Idata6,
  output logic [7:0]           Idata7,
  input  logic                 write_o,
  input  logic [7:0]           ostate,
  input  logic [RES_W-1:0]     Odata0,
  input  logic [RES_W-1:0]     Odata1,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*RES_W-1:0]   res_data,
  output logic                 ovf
`ifdef CONV_FEEDER_CHECK_EN
  ,
  output logic                 chk_err
`endif
);

  localparam int TOTAL = KBEATS + IBEATS;
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int DW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);
  localparam logic [DW-1:0] LAST_DRN = DW'(DRAIN_CYC - 1);

  state_t            state;
  logic [IW-1:0]     widx;
  logic [IW-1:0]     ridx;
  logic [DW-1:0]     dcnt;
  logic [BEAT_W-1:0] beat_buf [TOTAL];
  logic [BEAT_W-1:0] beat_q;
  logic              load_hs;
  logic              start_job;

  assign load_hs   = src_valid && src_ready;
  assign start_job = (state == IDLE) && go;

  // --------------------------------------------------------------------------
  // Job sequencer. Every engine-facing output is a register updated here.
  // ridx is the index of the beat currently presented on Idata.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      widx       <= '0;
      ridx       <= '0;
      dcnt       <= '0;
      beat_q     <= '0;
      start_conv <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      src_ready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state     <= LOAD;
            src_ready <= 1'b1;
            busy      <= 1'b1;
            widx      <= '0;
          end
        end
        LOAD: begin
          if (load_hs) begin
            widx <= widx + 1'b1;
            if (widx == LAST_IDX) begin
              state      <= ARM;
              src_ready  <= 1'b0;
              start_conv <= 1'b1;
              beat_q     <= '0;
            end
          end
        end
        ARM: begin
          state  <= STREAM;
          ridx   <= '0;
          beat_q <= beat_buf[0];
        end
        STREAM: begin
          if (ridx == LAST_IDX) begin
            state  <= DRAIN;
            beat_q <= '0;
            dcnt   <= '0;
          end else begin
            ridx   <= ridx + 1'b1;
            beat_q <= beat_buf[ridx + 1'b1];
          end
        end
        DRAIN: begin
          if (dcnt == LAST_DRN) begin
            state      <= DONE;
            start_conv <= 1'b0;
            done       <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          start_conv <= 1'b0;
          busy       <= 1'b0;
          src_ready  <= 1'b0;
        end
      endcase
    end
  end

  // Beat storage needs no reset: it is always written before it is replayed.
  always_ff @(posedge clk) begin
    if (load_hs) beat_buf[widx] <= src_data;
  end

  assign Idata0 = beat_q[7:0];
  assign Idata1 = beat_q[15:8];
  assign Idata2 = beat_q[23:16];
  assign Idata3 = beat_q[31:24];
  assign Idata4 = beat_q[39:32];
  assign Idata5 = beat_q[47:40];
  assign Idata6 = beat_q[55:48];
  assign Idata7 = beat_q[63:56];

  // --------------------------------------------------------------------------
  // Result capture: one push per rising edge of write_o while the engine is
  // running, so a strobe held high for several cycles is counted once.
  // --------------------------------------------------------------------------
  logic write_o_q;
  logic cap_win;
  logic res_push;
  logic res_pop;
  logic fifo_full;
  logic fifo_empty;

  assign cap_win   = (state == STREAM) || (state == DRAIN);
  assign res_push  = cap_win && write_o && !write_o_q;
  assign res_valid = !fifo_empty;
  assign res_pop   = res_ready && res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_o_q <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      write_o_q <= write_o;
      if (start_job) begin
        ovf <= 1'b0;
      end else if (res_push && fifo_full && !res_pop) begin
        ovf <= 1'b1;
      end
    end
  end

  conv_res_fifo #(
    .WIDTH (2*RES_W),
    .DEPTH (RDEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (res_push),
    .din   ({Odata1, Odata0}),
    .pop   (res_pop),
    .dout  (res_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef CONV_FEEDER_CHECK_EN
  // Engine must be out of idle throughout the run and must report the
  // kernel-load state in the first streaming cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (start_job) begin
      chk_err <= 1'b0;
    end else if (cap_win && ((ostate == ST_IDLE) ||
               ((state == STREAM) && (ridx == '0) && (ostate != ST_KERN)))) begin
      chk_err <= 1'b1;
    end
  end
`else
  logic unused_chk;
  assign unused_chk = ^{ostate, ST_IDLE, ST_KERN};
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_conv_feeder
// Purpose  : Self-checking bench for conv_feeder. Streamed beats and engine
//            results are pushed to scoreboard queues as they are driven and
//            compared when the feeder presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_feeder;

  localparam int KB  = 2;
  localparam int IB  = 16;
  localparam int DC  = 8;
  localparam int RD  = 4;
  localparam int TOT = KB + IB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        src_valid = 1'b0;
  logic [63:0] src_data = '0;
  logic        write_o = 1'b0;
  logic [7:0]  ostate = '0;
  logic [24:0] Odata0 = '0;
  logic [24:0] Odata1 = '0;
  logic        res_ready = 1'b0;

  logic        busy, done, src_ready, start_conv, res_valid, ovf;
  logic [7:0]  Idata0, Idata1, Idata2, Idata3, Idata4, Idata5, Idata6, Idata7;
  logic [49:0] res_data;
`ifdef CONV_FEEDER_CHECK_EN
  logic        chk_err;
`endif

  conv_feeder #(
    .KBEATS    (KB),
    .IBEATS    (IB),
    .DRAIN_CYC (DC),
    .RDEPTH    (RD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .busy       (busy),
    .done       (done),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .start_conv (start_conv),
    .Idata0     (Idata0),
    .Idata1     (Idata1),
    .Idata2     (Idata2),
    .Idata3     (Idata3),
    .Idata4     (Idata4),
    .Idata5     (Idata5),
    .Idata6     (Idata6),
    .Idata7     (Idata7),
    .write_o    (write_o),
    .ostate     (ostate),
    .Odata0     (Odata0),
    .Odata1     (Odata1),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .ovf        (ovf)
`ifdef CONV_FEEDER_CHECK_EN
    ,
    .chk_err    (chk_err)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          ev_n;
  bit          exp_ovf;
  bit          exp_chk;
  bit          bad_mode;
  logic [63:0] exp_beats[$];
  logic [49:0] exp_res[$];
  logic [63:0] beat_obs;

  assign beat_obs = {Idata7, Idata6, Idata5, Idata4, Idata3, Idata2, Idata1, Idata0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_beat(input int k, input int seed);
    logic [63:0] b;
    for (int n = 0; n < 8; n++) b[8*n +: 8] = 8'(k + 1) + 8'(n * seed);
    return b;
  endfunction

  // Compare the FIFO head against the scoreboard; a pop is whatever the
  // handshake at the coming edge will consume.
  task automatic service();
    logic [49:0] e;
    chk("res_valid", 64'(res_valid), 64'(exp_res.size() != 0));
    if (res_valid && res_ready && exp_res.size() != 0) begin
      e = exp_res.pop_front();
      chk("res_data", 64'(res_data), 64'(e));
    end
  endtask

  task automatic start_job(input bit bad);
    go = 1'b1;
    @(negedge clk);
    go       = 1'b0;
    ev_n     = 0;
    exp_ovf  = 1'b0;
    bad_mode = bad;
    exp_chk  = bad;
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_src_ready", 64'(src_ready), 64'd1);
    chk("go_clears_ovf", 64'(ovf), 64'd0);
`ifdef CONV_FEEDER_CHECK_EN
    chk("go_clears_chk", 64'(chk_err), 64'd0);
`endif
  endtask

  task automatic load_beats(input bit bp, input int seed);
    int k = 0;
    int guard = 0;
    while (k < TOT && guard < 200) begin
      if (bp && (guard % 2 == 1)) begin
        src_valid = 1'b0;
        src_data  = 64'hDEAD_BEEF_0BAD_F00D;
      end else begin
        src_valid = 1'b1;
        src_data  = mk_beat(k, seed);
      end
      if (src_valid && src_ready) begin
        exp_beats.push_back(src_data);
        k++;
      end
      guard++;
      @(negedge clk);
    end
    src_valid = 1'b0;
    if (k < TOT) chk("load_timeout", 64'(k), 64'(TOT));
  endtask

  task automatic arm_check();
    chk("arm_start_conv", 64'(start_conv), 64'd1);
    chk("arm_idata_zero", beat_obs, 64'd0);
    chk("arm_src_ready", 64'(src_ready), 64'd0);
    @(negedge clk);
  endtask

  task automatic stream_beats(input int n, input logic [31:0] evmask);
    for (int k = 0; k < n; k++) begin
      if (exp_beats.size() != 0) chk("beat", beat_obs, exp_beats.pop_front());
      else chk("beat_underflow", 64'd1, 64'd0);
      chk("stream_start_conv", 64'(start_conv), 64'd1);
      service();
      ostate = bad_mode ? 8'h00 : ((k == 0) ? 8'h01 : 8'h02);
      if (evmask[k]) begin
        write_o = 1'b1;
        Odata1  = 25'h1A + 25'(ev_n * 16);
        Odata0  = 25'h3 + 25'(ev_n);
        ev_n++;
        if (exp_res.size() < RD) exp_res.push_back({Odata1, Odata0});
        else exp_ovf = 1'b1;
      end else begin
        write_o = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic tail();
    for (int i = 0; i < DC; i++) begin
      chk("drain_idata_zero", beat_obs, 64'd0);
      chk("drain_start_conv", 64'(start_conv), 64'd1);
      service();
      write_o = 1'b0;
      ostate  = bad_mode ? 8'h00 : 8'h02;
      @(negedge clk);
    end
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_start_conv", 64'(start_conv), 64'd0);
    chk("done_ovf", 64'(ovf), 64'(exp_ovf));
`ifdef CONV_FEEDER_CHECK_EN
    chk("done_chk_err", 64'(chk_err), 64'(exp_chk));
`endif
    service();
    ostate = 8'h00;
    @(negedge clk);
    chk("done_cleared", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    service();
  endtask

  task automatic drain_results();
    res_ready = 1'b1;
    for (int i = 0; i < 4 * RD && exp_res.size() != 0; i++) begin
      service();
      @(negedge clk);
    end
    if (exp_res.size() != 0) chk("drain_timeout", 64'(exp_res.size()), 64'd0);
    chk("fifo_empty_after_drain", 64'(res_valid), 64'd0);
  endtask

  task automatic run_job(input bit bp, input int seed, input logic [31:0] evmask,
                         input bit rr, input bit bad);
    res_ready = rr;
    start_job(bad);
    load_beats(bp, seed);
    arm_check();
    stream_beats(TOT, evmask);
    tail();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_start_conv", 64'(start_conv), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_idata", beat_obs, 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
`ifdef CONV_FEEDER_CHECK_EN
    chk("rst_chk_err", 64'(chk_err), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    // Beats offered while idle must not be accepted
    src_valid = 1'b1;
    @(negedge clk);
    chk("idle_src_ready", 64'(src_ready), 64'd0);
    src_valid = 1'b0;

    // Plain job, results at beats 5 and 9 drained as they arrive
    run_job(1'b0, 16, 32'h0000_0220, 1'b1, 1'b0);
    // Back-pressure on the source
    run_job(1'b1, 3, 32'h0, 1'b1, 1'b0);
    // Overflow: RD+1 edges with no reader
    run_job(1'b0, 5, 32'h0000_02AA, 1'b0, 1'b0);
    drain_results();

    // Reset mid-stream with one result parked in the FIFO
    res_ready = 1'b0;
    start_job(1'b0);
    load_beats(1'b0, 7);
    arm_check();
    stream_beats(6, 32'h0000_0004);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_start_conv", 64'(start_conv), 64'd0);
    chk("abort_res_valid", 64'(res_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_idata", beat_obs, 64'd0);
    exp_beats.delete();
    exp_res.delete();
    write_o = 1'b0;
    ostate  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(1'b0, 9, 32'h0000_0010, 1'b1, 1'b0);

`ifdef CONV_FEEDER_CHECK_EN
    // Engine stuck in idle during the run, then a clean job clears the flag
    run_job(1'b0, 11, 32'h0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("chk_err_sticky", 64'(chk_err), 64'd1);
    run_job(1'b0, 13, 32'h0, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
